// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and data-width default for the load/store unit
package lsu_pkg;
  localparam int XLEN_DEF = 64;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: extracts/extends a load from a memory line and merges store data into it
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] line,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_val,
  output logic [XLEN-1:0] st_line
);
  logic [XLEN-1:0] ones, mask, shifted, sized;
  logic [5:0] sh;
  logic [6:0] nbits;
  logic sign;
  always_comb begin
    ones    = '1;
    sh      = {off, 3'b000};
    nbits   = 7'd8 << funct3[1:0];
    mask    = ~(ones << nbits);
    shifted = line >> sh;
    sized   = shifted & mask;
    // top bit of the access width: mask with its own right shift removed
    sign    = |(shifted & (mask ^ (mask >> 1)));
    ld_val  = funct3 == 3'b111 ? '0 : (!funct3[2] && sign) ? (sized | ~mask) : sized;
    st_line = (line & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: handshaked load/store front end for data_memory with read-modify-write sub-line stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 128,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic [IDX_W-1:0]  mem_read_addr,
  input  logic [XLEN-1:0]   mem_read_data,
  output logic              mem_write,
  output logic [IDX_W-1:0]  mem_write_addr,
  output logic [XLEN-1:0]   mem_write_data
);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [2:0] off, f3;
  logic we, acc, err;
  logic [XLEN-1:0] wdata, wr_line, ld_val, st_line;
  lsu_align #(.XLEN(XLEN)) u_align (
    .line(mem_read_data), .off(off), .funct3(f3), .wdata(wdata),
    .ld_val(ld_val), .st_line(st_line)
  );
  assign err = (req_we ? req_funct3[2] : req_funct3 == 3'b111)
             || (req_funct3[1:0] == 2'd1 && req_addr[0])
             || (req_funct3[1:0] == 2'd2 && |req_addr[1:0])
             || (req_funct3[1:0] == 2'd3 && |req_addr[2:0])
             || |req_addr[ADDR_W-1:IDX_W+3];
  assign acc = state == IDLE && req_valid;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = err ? RESP : !req_we ? LOAD : req_funct3 == F3_D ? WRITE : RMW_RD;
      LOAD:    state_nx = RESP;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // req_ready is gated by reset so it reads 0 while reset is held
    req_ready      = state == IDLE && reset;
    resp_valid     = state == RESP;
    mem_read       = state == LOAD || state == RMW_RD;
    mem_write      = state == WRITE && we;
    mem_read_addr  = state != IDLE ? idx : '0;
    mem_write_addr = state != IDLE ? idx : '0;
    mem_write_data = state == WRITE ? wr_line : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      off        <= '0;
      f3         <= '0;
      we         <= 1'b0;
      wdata      <= '0;
      wr_line    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        idx        <= req_addr[IDX_W+2:3];
        off        <= req_addr[2:0];
        f3         <= req_funct3;
        we         <= req_we;
        wdata      <= req_wdata;
        wr_line    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= err;
      end
      if (state == LOAD) resp_rdata <= ld_val;
      if (state == RMW_RD) wr_line <= st_line;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random transactions checked against a byte-level memory model
module tb_load_store_unit;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic resp_valid, resp_ready = 1, resp_err;
  logic [63:0] resp_rdata;
  logic mem_read, mem_write;
  logic [6:0] mem_read_addr, mem_write_addr;
  logic [63:0] mem_read_data, mem_write_data;
  logic [63:0] mem [128];
  logic [63:0] ref_mem [128];
  int checks = 0, errors = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_read_addr];
  always @(posedge clk) if (mem_write) mem[mem_write_addr] <= mem_write_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] line, input int off, input logic [2:0] f3);
    int sz = 1 << f3[1:0];
    logic [63:0] v = 0;
    for (int i = 0; i < sz; i++) v[i*8 +: 8] = line[(off+i)*8 +: 8];
    if (!f3[2] && sz < 8 && v[sz*8-1])
      for (int i = sz; i < 8; i++) v[i*8 +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wd, input int stall);
    int sz = 1 << f3[1:0];
    int idx = int'(addr[9:3]);
    int off = int'(addr[2:0]);
    int lat, exp_lat, rd_cnt, wr_cnt;
    logic exp_e;
    logic [63:0] exp_d = 0, new_line, seen_line = 0;
    logic [6:0] seen_idx = 0;
    exp_e = (we ? f3[2] : f3 == 3'b111) || (addr % sz != 0) || (addr >= 32'd1024);
    new_line = ref_mem[idx];
    if (!exp_e && !we) exp_d = model_load(ref_mem[idx], off, f3);
    if (!exp_e && we) for (int i = 0; i < sz; i++) new_line[(off+i)*8 +: 8] = wd[i*8 +: 8];
    exp_lat = exp_e ? 1 : (!we || sz == 8) ? 2 : 3;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = stall == 0;
    @(negedge clk);
    req_valid = 0;
    lat = 1; rd_cnt = 0; wr_cnt = 0;
    while (!resp_valid && lat < 8) begin
      if (mem_read && mem_write) check("rd_wr_excl", 1, 0);
      rd_cnt += int'(mem_read);
      if (mem_write) begin wr_cnt++; seen_line = mem_write_data; seen_idx = mem_write_addr; end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rdata", resp_rdata, exp_d);
    check("err", resp_err, exp_e);
    check("rd_cnt", rd_cnt, (!exp_e && !(we && sz == 8)) ? 1 : 0);
    check("wr_cnt", wr_cnt, (!exp_e && we) ? 1 : 0);
    if (wr_cnt == 1) begin
      check("wr_line", seen_line, new_line);
      check("wr_idx", seen_idx, idx);
    end
    for (int s = 0; s < stall; s++) begin
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, exp_d);
      check("hold_ready", req_ready, 0);
      req_valid = 1; req_we = 0; req_funct3 = 3'b011; req_addr = 32'h40;
      @(negedge clk);
    end
    check("resp_ready_low", req_ready, 0);
    req_valid = 0; resp_ready = 1;
    @(negedge clk);
    check("resp_done", resp_valid, 0);
    if (!exp_e && we) ref_mem[idx] = new_line;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0] f;
    for (int i = 0; i < 128; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_rw", {mem_read, mem_write}, 0);
    check("rst_wdata", mem_write_data, 0);
    check("rst_addr", {mem_read_addr, mem_write_addr}, 0);
    reset = 1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    do_txn(1, 3'b011, 32'h18, 64'h1122334455667788, 0);
    do_txn(0, 3'b011, 32'h18, 0, 0);
    do_txn(1, 3'b000, 32'h1D, 64'hAB, 0);
    do_txn(0, 3'b011, 32'h18, 0, 0);
    do_txn(0, 3'b000, 32'h1D, 0, 0);
    do_txn(0, 3'b100, 32'h1D, 0, 0);
    do_txn(0, 3'b010, 32'h06, 0, 0);
    do_txn(0, 3'b001, 32'h400, 0, 0);
    do_txn(1, 3'b010, 32'h20, 64'h80000000, 0);
    do_txn(0, 3'b110, 32'h20, 0, 5);
    do_txn(0, 3'b010, 32'h20, 0, 0);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b001; req_addr = 32'h1A; req_wdata = 64'h5555;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("sh_write_cycle", mem_write, 1);
    reset = 0;
    #1;
    check("abort_write", mem_write, 0);
    check("abort_resp", resp_valid, 0);
    check("abort_addr", mem_write_addr, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("rel_ready", req_ready, 1);
    check("rel_resp", resp_valid, 0);
    do_txn(0, 3'b011, 32'h18, 0, 0);
    do_txn(1, 3'b100, 32'h08, 64'h1234, 0);
    do_txn(0, 3'b111, 32'h08, 0, 0);
    for (int n = 0; n < 300; n++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f[1:0]) - 1);
      do_txn(1'($urandom_range(0, 1)), f, a, {$urandom, $urandom}, $urandom_range(0, 7) == 0 ? 2 : 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
